// File: rtl/reg_pipe_n.sv
// reg_pipe_n: elastic register pipeline, WIDTH-bit data over DEPTH stages with
// valid/ready handshake, bubble collapse, synchronous flush and occupancy count.
module reg_pipe_n #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] D,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Q,
    output logic [OCC_W-1:0] OCC
);

    // Stage 0 is the input side, stage DEPTH-1 drives Q.
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] r    [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];
    logic [OCC_W-1:0] occ_sum;

    // Ready chain: a stage can load when it or any stage downstream of it is
    // empty, or the consumer is taking Q. Built with a running accumulator
    // walking from the output side so no bit of rdy feeds back into itself.
    always_comb begin : ready_chain
        logic acc;
        acc = OUT_READY;
        rdy = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            acc = acc | ~v[DEPTH-1-k];
            rdy[DEPTH-1-k] = acc;
        end
    end

    // Upstream view of each stage: the producer for stage 0, the previous stage otherwise.
    always_comb begin : upstream_sel
        up_v    = '0;
        up_v[0] = IN_VALID;
        up_d[0] = D;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            up_v[k] = v[k-1];
            up_d[k] = r[k-1];
        end
    end

    // Stage valid flags: advance where ready, hold on stall, clear on flush.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            v <= '0;
        end else if (FLUSH) begin
            v <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    v[k] <= up_v[k];
                end
            end
        end
    end

    // Stage data: load only on a valid upstream beat into a ready stage; flush leaves data untouched.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r[k] <= RESET_VAL;
            end
        end else if (!FLUSH) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (rdy[k] && up_v[k]) begin
                    r[k] <= up_d[k];
                end
            end
        end
    end

    // Occupancy: population count of the registered valid flags.
    always_comb begin : occupancy
        occ_sum = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            occ_sum = occ_sum + OCC_W'(v[k]);
        end
    end

    assign IN_READY  = rdy[0];
    assign OUT_VALID = v[DEPTH-1];
    assign Q         = r[DEPTH-1];
    assign OCC       = occ_sum;

endmodule

// File: tb/tb_reg_pipe_n.sv
// tb_reg_pipe_n: directed bench for reg_pipe_n (DEPTH = 3, RESET_VAL = 16'hA5A5)
// with a slot-movement reference model and a consumer-side order scoreboard.
module tb_reg_pipe_n;

    localparam int          WIDTH = 16;
    localparam int          DEPTH = 3;
    localparam logic [15:0] RV    = 16'hA5A5;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        FLUSH;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] D;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] Q;
    logic [1:0]  OCC;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic [15:0] got   [$];
    logic [15:0] exp_q [$];

    reg_pipe_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .FLUSH     (FLUSH),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .D         (D),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Q         (Q),
        .OCC       (OCC)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: beats occupy slots; each edge every beat steps one slot
    // towards the output if the slot ahead is (or becomes) free, then the
    // producer fills slot 0 if it is free. Flush empties all slots.
    bit          mv [DEPTH];
    logic [15:0] md [DEPTH];

    always @(posedge CLK or negedge RESETN) begin : model
        bit          nv [DEPTH];
        logic [15:0] nd [DEPTH];
        bit          room;
        if (!RESETN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mv[i] <= 1'b0;
                md[i] <= RV;
            end
        end else begin
            nv = mv;
            nd = md;
            if (FLUSH) begin
                for (int i = 0; i < DEPTH; i++) nv[i] = 1'b0;
            end else begin
                room = OUT_READY;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (nv[i] && room) begin
                        if (i < DEPTH - 1) begin
                            nv[i+1] = 1'b1;
                            nd[i+1] = nd[i];
                        end
                        nv[i] = 1'b0;
                    end
                    room = !nv[i];
                end
                if (IN_VALID && !nv[0]) begin
                    nv[0] = 1'b1;
                    nd[0] = D;
                end
            end
            mv <= nv;
            md <= nd;
        end
    end

    // Every-cycle comparison against the model, plus consumer capture.
    always @(negedge CLK) begin : cmp
        int occ;
        occ = 0;
        for (int i = 0; i < DEPTH; i++) occ += int'(mv[i]);
        chk("occ", 32'(OCC), 32'(occ));
        chk("out_valid", 32'(OUT_VALID), 32'(mv[DEPTH-1]));
        chk("in_ready", 32'(IN_READY), 32'(OUT_READY || (occ < DEPTH)));
        if (mv[DEPTH-1]) chk("q", 32'(Q), 32'(md[DEPTH-1]));
        if (RESETN && OUT_VALID && OUT_READY) got.push_back(Q);
    end

    task automatic cyc(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
        IN_VALID  = iv;
        D         = d;
        OUT_READY = ordy;
        FLUSH     = fl;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic chk_got(input string name);
        chk({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk(name, 32'(got[i]), 32'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_q"}, 32'(Q), 32'(16'hA5A5));
        chk({name, "_out_valid"}, 32'(OUT_VALID), 32'd0);
        chk({name, "_occ"}, 32'(OCC), 32'd0);
        chk({name, "_in_ready"}, 32'(IN_READY), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        RESETN = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; D = '0; OUT_READY = 1'b0;
        #2 RESETN = 1'b0;
        #1 check_reset_outputs("por");
        @(posedge CLK); #2 RESETN = 1'b1;
        @(posedge CLK); #1;

        // Streaming, 1..10 back to back with consumer always ready.
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b1, 16'(k), 1'b1, 1'b0);
            if (k == 2) chk("lat_not_yet", 32'(OUT_VALID), 32'd0);
            if (k == 3) begin
                chk("lat_valid", 32'(OUT_VALID), 32'd1);
                chk("lat_q", 32'(Q), 32'd1);
            end
            if (k == 6) chk("stream_occ", 32'(OCC), 32'd3);
        end
        idle(6);
        for (int k = 1; k <= 10; k++) exp_q.push_back(16'(k));
        chk_got("stream_order");

        // Backpressure: three accepted, fourth refused until consumer drains.
        cyc(1'b1, 16'd1, 1'b0, 1'b0);
        cyc(1'b1, 16'd2, 1'b0, 1'b0);
        cyc(1'b1, 16'd3, 1'b0, 1'b0);
        chk("bp_full_occ", 32'(OCC), 32'd3);
        chk("bp_full_ready", 32'(IN_READY), 32'd0);
        cyc(1'b1, 16'd4, 1'b0, 1'b0);
        cyc(1'b1, 16'd4, 1'b0, 1'b0);
        chk("bp_hold_occ", 32'(OCC), 32'd3);
        chk("bp_hold_q", 32'(Q), 32'd1);
        chk("bp_hold_ready", 32'(IN_READY), 32'd0);
        cyc(1'b1, 16'd4, 1'b1, 1'b0);
        cyc(1'b1, 16'd5, 1'b1, 1'b0);
        idle(5);
        for (int k = 1; k <= 5; k++) exp_q.push_back(16'(k));
        chk_got("bp_order");

        // Bubble collapse: build V = {1,0,1}, then push into the gap while stalled.
        cyc(1'b1, 16'h0011, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        cyc(1'b1, 16'h0022, 1'b0, 1'b0);
        chk("bubble_occ2", 32'(OCC), 32'd2);
        chk("bubble_q", 32'(Q), 32'h0011);
        chk("bubble_ready", 32'(IN_READY), 32'd1);
        cyc(1'b1, 16'h0033, 1'b0, 1'b0);
        chk("bubble_occ3", 32'(OCC), 32'd3);
        chk("bubble_full_ready", 32'(IN_READY), 32'd0);
        idle(5);
        exp_q.push_back(16'h0011); exp_q.push_back(16'h0022); exp_q.push_back(16'h0033);
        chk_got("bubble_order");

        // Flush while full, with an input beat and an output transfer in the flush cycle.
        cyc(1'b1, 16'h0101, 1'b0, 1'b0);
        cyc(1'b1, 16'h0102, 1'b0, 1'b0);
        cyc(1'b1, 16'h0103, 1'b0, 1'b0);
        cyc(1'b1, 16'hDEAD, 1'b1, 1'b1);
        chk("flush_occ", 32'(OCC), 32'd0);
        chk("flush_valid", 32'(OUT_VALID), 32'd0);
        idle(5);
        exp_q.push_back(16'h0101);
        chk_got("flush_order");

        // Full with simultaneous input and output for six cycles.
        cyc(1'b1, 16'h0201, 1'b0, 1'b0);
        cyc(1'b1, 16'h0202, 1'b0, 1'b0);
        cyc(1'b1, 16'h0203, 1'b0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            IN_VALID = 1'b1; D = 16'(16'h0204 + j); OUT_READY = 1'b1; FLUSH = 1'b0;
            #1;
            chk("sim_ready", 32'(IN_READY), 32'd1);
            chk("sim_occ", 32'(OCC), 32'd3);
            @(posedge CLK); #1;
        end
        idle(5);
        for (int k = 0; k < 9; k++) exp_q.push_back(16'(16'h0201 + k));
        chk_got("sim_order");

        // Asynchronous reset mid-cycle with the pipeline full.
        cyc(1'b1, 16'h0301, 1'b0, 1'b0);
        cyc(1'b1, 16'h0302, 1'b0, 1'b0);
        cyc(1'b1, 16'h0303, 1'b0, 1'b0);
        IN_VALID = 1'b0;
        #2 RESETN = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge CLK); #2 RESETN = 1'b1;
        @(posedge CLK); #1;
        cyc(1'b1, 16'h0401, 1'b1, 1'b0);
        cyc(1'b1, 16'h0402, 1'b1, 1'b0);
        idle(5);
        exp_q.push_back(16'h0401); exp_q.push_back(16'h0402);
        chk_got("post_reset_order");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
